// File: rtl/key_action_decoder.sv
// Frame-aligned keyboard action decoder: turns four raw USB keycode slots into
// held/press/release actions, a resolved move direction and a buffered jump request.
module key_action_decoder #(
  parameter logic [7:0]  KEY_LEFT        = 8'h04,
  parameter logic [7:0]  KEY_RIGHT       = 8'h07,
  parameter logic [7:0]  KEY_JUMP        = 8'h2C,
  parameter logic [7:0]  KEY_JUMP_ALT    = 8'h1A,
  parameter int unsigned JUMP_BUF_FRAMES = 6
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic [31:0] keycode,
  input  logic        jump_ack,
  output logic        frame_tick,
  output logic [2:0]  held,
  output logic [2:0]  press,
  output logic [2:0]  released,
  output logic [1:0]  move_dir,
  output logic        jump_req
);

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_t;

  localparam logic [3:0] JUMP_LOAD = 4'(JUMP_BUF_FRAMES);

  logic        vs_s1_q, vs_s1_d;
  logic        vs_s2_q, vs_s2_d;
  logic        vs_prev_q, vs_prev_d;
  logic        tick_q, tick_d;
  logic        frame_tick_q, frame_tick_d;
  logic [31:0] kc_a_q, kc_a_d;
  logic [31:0] kc_b_q, kc_b_d;
  logic [2:0]  held_q, held_d;
  logic [2:0]  press_q, press_d;
  logic [2:0]  rel_q, rel_d;
  dir_t        dir_q, dir_d;
  logic        jump_req_q, jump_req_d;
  logic [3:0]  jcnt_q, jcnt_d;

  logic [2:0]  new_keys;
  logic        snap_ok;

  // Slot value 00 means "no key" and must never match, even for a zero code.
  function automatic logic slot_match(input logic [31:0] kc, input logic [7:0] code);
    logic m;
    m = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((kc[i*8 +: 8] == code) && (kc[i*8 +: 8] != 8'h00)) m = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    vs_s1_d      = vsync;
    vs_s2_d      = vs_s1_q;
    vs_prev_d    = vs_s2_q;
    tick_d       = vs_prev_q & ~vs_s2_q;
    frame_tick_d = tick_q;
    kc_a_d       = keycode;
    kc_b_d       = kc_a_q;
    held_d       = held_q;
    press_d      = '0;
    rel_d        = '0;
    dir_d        = dir_q;
    jump_req_d   = jump_req_q;
    jcnt_d       = jcnt_q;

    new_keys = {slot_match(kc_a_q, KEY_JUMP) | slot_match(kc_a_q, KEY_JUMP_ALT),
                slot_match(kc_a_q, KEY_RIGHT),
                slot_match(kc_a_q, KEY_LEFT)};
    // A snapshot that changed across the last two samples may be torn; skip it.
    snap_ok = tick_q && (kc_a_q == kc_b_q);

    if (snap_ok) begin
      held_d  = new_keys;
      press_d = new_keys & ~held_q;
      rel_d   = ~new_keys & held_q;
      unique case (new_keys[1:0])
        2'b00: dir_d = DIR_NONE;
        2'b01: dir_d = DIR_LEFT;
        2'b10: dir_d = DIR_RIGHT;
        default: begin
          // Both held: the most recent press wins; a simultaneous press is ambiguous.
          if (press_d[0] && press_d[1]) dir_d = DIR_NONE;
          else if (press_d[0])          dir_d = DIR_LEFT;
          else if (press_d[1])          dir_d = DIR_RIGHT;
        end
      endcase
    end

    if (snap_ok && press_d[2]) begin
      jump_req_d = 1'b1;
      jcnt_d     = JUMP_LOAD;
    end else if (jump_ack && jump_req_q) begin
      jump_req_d = 1'b0;
      jcnt_d     = '0;
    end else if (tick_q && (jcnt_q != '0)) begin
      jcnt_d = jcnt_q - 4'd1;
      if (jcnt_q == 4'd1) jump_req_d = 1'b0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      vs_prev_q    <= 1'b0;
      tick_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      kc_a_q       <= '0;
      kc_b_q       <= '0;
      held_q       <= '0;
      press_q      <= '0;
      rel_q        <= '0;
      dir_q        <= DIR_NONE;
      jump_req_q   <= 1'b0;
      jcnt_q       <= '0;
    end else begin
      vs_s1_q      <= vs_s1_d;
      vs_s2_q      <= vs_s2_d;
      vs_prev_q    <= vs_prev_d;
      tick_q       <= tick_d;
      frame_tick_q <= frame_tick_d;
      kc_a_q       <= kc_a_d;
      kc_b_q       <= kc_b_d;
      held_q       <= held_d;
      press_q      <= press_d;
      rel_q        <= rel_d;
      dir_q        <= dir_d;
      jump_req_q   <= jump_req_d;
      jcnt_q       <= jcnt_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign held       = held_q;
  assign press      = press_q;
  assign released   = rel_q;
  assign move_dir   = dir_q;
  assign jump_req   = jump_req_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Directed bench for key_action_decoder: table of per-frame vectors plus
// hand-written sequences for jump ack, torn snapshots and mid-frame reset.
module tb_key_action_decoder;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic [31:0] keycode;
  logic        jump_ack;
  logic        frame_tick;
  logic [2:0]  held;
  logic [2:0]  press;
  logic [2:0]  released;
  logic [1:0]  move_dir;
  logic        jump_req;

  int checks = 0;
  int errors = 0;

  key_action_decoder #(
    .KEY_LEFT(8'h04),
    .KEY_RIGHT(8'h07),
    .KEY_JUMP(8'h2C),
    .KEY_JUMP_ALT(8'h1A),
    .JUMP_BUF_FRAMES(6)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset(reset),
    .vsync(vsync),
    .keycode(keycode),
    .jump_ack(jump_ack),
    .frame_tick(frame_tick),
    .held(held),
    .press(press),
    .released(released),
    .move_dir(move_dir),
    .jump_req(jump_req)
  );

  always #20 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [31:0] kc;
    logic [2:0]  held;
    logic [2:0]  press;
    logic [2:0]  rel;
    logic [1:0]  dir;
    logic        jr;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vsync frame: optional torn keycode change and jump_ack on the tick edge.
  task automatic frame(input logic [31:0] kc, input bit glitch, input bit ack_tick,
                       input logic [2:0] e_held, input logic [2:0] e_press,
                       input logic [2:0] e_rel, input logic [1:0] e_dir,
                       input logic e_jr, input string tag);
    int lat;
    lat = 0;
    @(negedge pixel_clk);
    if (!glitch) keycode = kc;
    repeat (3) @(negedge pixel_clk);
    vsync = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge pixel_clk);
      #1;
      if (ack_tick && cyc == 4) jump_ack = 1'b0;
      if (frame_tick) begin
        lat = cyc;
        break;
      end
      if (glitch && cyc == 2) keycode = kc;
      if (ack_tick && cyc == 3) jump_ack = 1'b1;
    end
    jump_ack = 1'b0;
    chk({tag, " latency"}, lat, 4);
    chk({tag, " held"}, held, e_held);
    chk({tag, " press"}, press, e_press);
    chk({tag, " release"}, released, e_rel);
    chk({tag, " move_dir"}, move_dir, e_dir);
    chk({tag, " jump_req"}, jump_req, e_jr);
    @(posedge pixel_clk);
    #1;
    chk({tag, " pulses_clear"}, {frame_tick, press, released}, 7'd0);
    vsync = 1'b1;
    repeat (2) @(posedge pixel_clk);
  endtask

  initial begin
    vecs[0]  = '{32'h00000000, 3'b000, 3'b000, 3'b000, 2'b00, 1'b0};
    vecs[1]  = '{32'h00000004, 3'b001, 3'b001, 3'b000, 2'b01, 1'b0};
    vecs[2]  = '{32'h00000000, 3'b000, 3'b000, 3'b001, 2'b00, 1'b0};
    vecs[3]  = '{32'h00000004, 3'b001, 3'b001, 3'b000, 2'b01, 1'b0};
    vecs[4]  = '{32'h00000704, 3'b011, 3'b010, 3'b000, 2'b10, 1'b0};
    vecs[5]  = '{32'h00000004, 3'b001, 3'b000, 3'b010, 2'b01, 1'b0};
    vecs[6]  = '{32'h00000000, 3'b000, 3'b000, 3'b001, 2'b00, 1'b0};
    vecs[7]  = '{32'h00000704, 3'b011, 3'b011, 3'b000, 2'b00, 1'b0};
    vecs[8]  = '{32'h00000700, 3'b010, 3'b000, 3'b001, 2'b10, 1'b0};
    vecs[9]  = '{32'h04000700, 3'b011, 3'b001, 3'b000, 2'b01, 1'b0};
    vecs[10] = '{32'h00070004, 3'b011, 3'b000, 3'b000, 2'b01, 1'b0};
    vecs[11] = '{32'h00000000, 3'b000, 3'b000, 3'b011, 2'b00, 1'b0};
    vecs[12] = '{32'h0000002C, 3'b100, 3'b100, 3'b000, 2'b00, 1'b1};
    vecs[13] = '{32'h00002C00, 3'b100, 3'b000, 3'b000, 2'b00, 1'b1};
    vecs[14] = '{32'h00000000, 3'b000, 3'b000, 3'b100, 2'b00, 1'b1};
    vecs[15] = '{32'h00000000, 3'b000, 3'b000, 3'b000, 2'b00, 1'b1};
    vecs[16] = '{32'h00000000, 3'b000, 3'b000, 3'b000, 2'b00, 1'b1};
    vecs[17] = '{32'h00000000, 3'b000, 3'b000, 3'b000, 2'b00, 1'b1};
    vecs[18] = '{32'h00000000, 3'b000, 3'b000, 3'b000, 2'b00, 1'b0};
    vecs[19] = '{32'h1A000000, 3'b100, 3'b100, 3'b000, 2'b00, 1'b1};
    vecs[20] = '{32'h00000000, 3'b000, 3'b000, 3'b100, 2'b00, 1'b1};

    reset    = 1'b1;
    vsync    = 1'b1;
    keycode  = '0;
    jump_ack = 1'b0;
    repeat (4) @(posedge pixel_clk);
    #1;
    chk("reset outputs", {frame_tick, held, press, released, move_dir, jump_req}, 13'd0);
    @(negedge pixel_clk);
    reset = 1'b0;
    repeat (4) @(posedge pixel_clk);

    for (int i = 0; i < 21; i++) begin
      frame(vecs[i].kc, 1'b0, 1'b0, vecs[i].held, vecs[i].press, vecs[i].rel,
            vecs[i].dir, vecs[i].jr, $sformatf("vec%0d", i));
    end

    // Ack mid-frame clears a pending request; ack while idle is ignored.
    frame(32'h0000002C, 1'b0, 1'b0, 3'b100, 3'b100, 3'b000, 2'b00, 1'b1, "jpress");
    repeat (6) @(posedge pixel_clk);
    #1;
    chk("jreq before ack", jump_req, 1'b1);
    @(negedge pixel_clk);
    jump_ack = 1'b1;
    @(posedge pixel_clk);
    #1;
    jump_ack = 1'b0;
    chk("jreq after ack", jump_req, 1'b0);
    @(negedge pixel_clk);
    jump_ack = 1'b1;
    @(posedge pixel_clk);
    #1;
    jump_ack = 1'b0;
    chk("idle ack ignored", jump_req, 1'b0);
    frame(32'h00000000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b100, 2'b00, 1'b0, "jrel");

    // Ack and new press on the same edge: press wins and reloads the counter.
    frame(32'h0000002C, 1'b0, 1'b0, 3'b100, 3'b100, 3'b000, 2'b00, 1'b1, "arm");
    frame(32'h00000000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b100, 2'b00, 1'b1, "cnt5");
    frame(32'h00000000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'b00, 1'b1, "cnt4");
    frame(32'h001A0000, 1'b0, 1'b1, 3'b100, 3'b100, 3'b000, 2'b00, 1'b1, "ackpress");
    for (int k = 1; k <= 6; k++) begin
      frame(32'h001A0000, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 2'b00, (k < 6),
            $sformatf("reload%0d", k));
    end
    frame(32'h00000000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b100, 2'b00, 1'b0, "relj");

    // Torn snapshot is rejected, then the stable one decodes.
    frame(32'h00000004, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 2'b00, 1'b0, "torn");
    frame(32'h00000004, 1'b0, 1'b0, 3'b001, 3'b001, 3'b000, 2'b01, 1'b0, "stable");

    // Mid-frame reset with left held: everything clears, next tick re-presses.
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    reset = 1'b1;
    repeat (2) @(posedge pixel_clk);
    #1;
    chk("midreset outputs", {frame_tick, held, press, released, move_dir, jump_req}, 13'd0);
    @(negedge pixel_clk);
    reset = 1'b0;
    repeat (3) @(posedge pixel_clk);
    frame(32'h00000004, 1'b0, 1'b0, 3'b001, 3'b001, 3'b000, 2'b01, 1'b0, "postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_action_decoder.md
Name: key_action_decoder

Overview:
- Sits between the USB keycode GPIO (4 keycode slots, 100 MHz MicroBlaze domain) and the ball/physics stage.
- Converts raw keycodes into frame-aligned, glitch-filtered game actions: held levels, press/release pulses, a resolved move direction, and a buffered jump request with an ack handshake.
- Runs on the 25 MHz pixel clock and uses vsync as its frame reference, so the ball logic sees exactly one coherent input update per frame.

Parameters:
- KEY_LEFT, 8'h04, USB HID code for left (A)
- KEY_RIGHT, 8'h07, USB HID code for right (D)
- KEY_JUMP, 8'h2C, primary jump code (Space)
- KEY_JUMP_ALT, 8'h1A, alternate jump code (W)
- JUMP_BUF_FRAMES, 6, frames a jump request stays pending without ack (1..15)

Ports:
- pixel_clk, in, 1, 25 MHz pixel clock
- reset, in, 1, synchronous, active-high
- vsync, in, 1, active-low vertical sync from the VGA controller
- keycode, in, 32, four 8-bit keycode slots [31:24],[23:16],[15:8],[7:0]; asynchronous to pixel_clk
- jump_ack, in, 1, one-cycle pulse from the consumer: jump request taken
- frame_tick, out, 1, one-cycle pulse per frame; all other outputs update with it
- held, out, 3, {jump,right,left} level state
- press, out, 3, {jump,right,left} rising-edge pulses, high only during frame_tick
- release, out, 3, {jump,right,left} falling-edge pulses, high only during frame_tick
- move_dir, out, 2, 00 none, 01 left, 10 right (11 never driven)
- jump_req, out, 1, pending jump request level

Behaviour:
- Reset is synchronous: all outputs, sync flops, counters and the last-direction register go to 0.
- vsync synchronizer: 2 flops, then an edge register. tick_int = 1 on the synced falling edge.
- frame_tick is registered from tick_int, so it rises 4 pixel_clk edges after the vsync fall at the pin.
- keycode sampling:
  - keycode is registered every cycle into kc_a, then kc_b.
  - When tick_int = 1: if kc_a == kc_b, the snapshot is valid and is decoded. Otherwise the snapshot is rejected and held keeps its prior value; press and release are 0 for that frame.
- Decode:
  - A key is held if any slot equals its code.
  - Slot value 8'h00 never matches, even if a parameter is 0.
  - jump = match(KEY_JUMP) or match(KEY_JUMP_ALT).
- Edges, computed at the edge where tick_int = 1 and visible while frame_tick = 1:
  - press = new & ~old
  - release = ~new & old
  - Both are 0 on every cycle where frame_tick = 0.
- move_dir, registered on tick:
  - Only left held: 01. Only right held: 10. Neither held: 00.
  - Both held: the direction pressed in the later frame wins (tracked by a last-direction register).
  - Both pressed in the same frame: 00 until one is released.
  - Release of the winning key while the other is still held: switch to the other direction.
- Jump buffer, a 4-bit down counter:
  - press[jump] sets jump_req = 1 and loads JUMP_BUF_FRAMES.
  - Each subsequent tick decrements the counter if it is nonzero. When the counter reaches 0, jump_req clears at that same edge.
  - jump_ack while jump_req = 1: jump_req = 0 and the counter = 0 at the next edge.
  - jump_ack while jump_req = 0: ignored.
  - jump_ack and a jump press on the same edge: the press wins (re-armed, counter reloaded).
  - A press while already pending: counter reloaded.
- Holding the jump key does not re-request; only a new press does.
- Reset asserted mid-frame: everything clears. The first tick after reset compares against held = 0, so keys already down produce press pulses.
- Consecutive ticks are at least one frame apart. No behaviour depends on vsync period beyond producing one tick per falling edge.

Test Plan:
- Reset, keycode = 0, toggle vsync → frame_tick pulses 4 cycles after each vsync fall; held = 000, move_dir = 00, jump_req = 0.
- keycode = 32'h00000004, one frame, then 0 → press = 001 and held = 001, move_dir = 01; next tick release = 001, held = 000, move_dir = 00.
- Left in slot0 at frame N, add 8'h07 in slot1 at frame N+1, drop 8'h07 at N+2 → move_dir = 01, then 10, then 01. Left and right both appearing in the same frame → move_dir = 00.
- keycode = 8'h2C, no ack, JUMP_BUF_FRAMES = 6 → jump_req high on the press tick, low at the 6th following tick. Repeat with jump_ack 10 cycles after the press → jump_req low the next cycle.
- jump_ack on the same edge as a new 8'h1A press while pending → jump_req stays 1, counter reloaded to 6.
- Change keycode on the cycle before tick_int so kc_a != kc_b → held unchanged, press = release = 000 for that frame. Assert reset mid-frame with a key held → all outputs 0; the next tick gives press = 001.
